// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN radix-2 shift-and-add multiplier around one ripple_adder.
// Optional build macro ZERO_SKIP_EN: zero operands complete without entering RUN.

module ripple_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry;

    always_comb begin
        carry[0] = c_in;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[N];
    end
endmodule

module shift_add_multiplier #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  mcand;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          c_out;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_step;
    logic          zero_op;

    assign addend = lo[0] ? mcand : '0;

    ripple_adder #(.N(N)) u_adder (
        .a    (hi),
        .b    (addend),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(c_out)
    );

    assign accept    = (state != RUN) && start;
    assign last_step = (state == RUN) && (cnt == CW'(N - 1));

`ifdef ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = zero_op ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1)) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = zero_op ? DONE : RUN;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The adder's carry-out becomes the top bit of the shifted partial product, so nothing is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
            if (zero_op) product <= '0;
        end else if (state == RUN) begin
            {hi, lo} <= {c_out, sum, lo[N-1:1]};
            cnt      <= cnt + 1'b1;
            if (last_step) product <= {c_out, sum, lo[N-1:1]};
        end
    end
endmodule
